rr_priority_arbiter: RTL and testbench



---
 rtl/arb_pkg.sv | 42 ++++
 rtl/lowest_set_finder.sv | 42 ++++
 rtl/rr_priority_arbiter.sv | 106 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared types and lowest-set-bit helpers for rr_priority_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    // Helpers work on a fixed maximum width; callers cast in and out,
    // so arbiters up to 64 requesters are supported.
    localparam int c_MAX_W    = 64;
    localparam int c_MAX_IDXW = 6;

    typedef logic [c_MAX_W-1:0]    vec_t;
    typedef logic [c_MAX_IDXW-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Isolate the lowest set bit (two's-complement trick).
    function automatic vec_t lowest_set_onehot(input vec_t v);
        return v & (~v + vec_t'(1));
    endfunction

    // Encode a one-hot vector to its bit index (zero for an all-zero input).
    function automatic idx_t onehot_to_idx(input vec_t oh);
        idx_t r_idx;
        r_idx = '0;
        for (int i = 0; i < c_MAX_W; i++) begin
            if (oh[i]) begin
                r_idx = r_idx | idx_t'(i);
            end
        end
        return r_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lowest_set_finder.sv
// ============================================================================
// Module   : lowest_set_finder
// Brief    : Combinational lowest-set-bit search starting at mask_from, with
//            wrap-around to the unmasked vector when nothing is at/above it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lowest_set_finder
    import arb_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [IDXW-1:0]  mask_from,
    output logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] onehot,
    output logic             none
);

    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_masked;
    logic [WIDTH-1:0] w_oh_masked;
    logic [WIDTH-1:0] w_oh_wrap;

    // Keep only bits at or above the starting position.
    assign w_mask   = {WIDTH{1'b1}} << mask_from;
    assign w_masked = vec & w_mask;

    // Both searches run in parallel; the wrap result is used only when the
    // masked vector is empty.
    assign w_oh_masked = WIDTH'(lowest_set_onehot(vec_t'(w_masked)));
    assign w_oh_wrap   = WIDTH'(lowest_set_onehot(vec_t'(vec)));

    assign onehot = (w_masked == '0) ? w_oh_wrap : w_oh_masked;
    assign idx    = IDXW'(onehot_to_idx(vec_t'(onehot)));
    assign none   = (vec == '0);

endmodule

`default_nettype wire

// File: rtl/rr_priority_arbiter.sv
// ============================================================================
// Module   : rr_priority_arbiter
// Brief    : Registered round-robin arbiter with valid/ready grant handshake.
//            Optional feature macro: RR_ARB_ROTATE_EN (round-robin rotation;
//            when undefined the arbiter is fixed priority, index 0 highest).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_arbiter
    import arb_pkg::*;
#(
    parameter int REQUESTERS = 16,
    localparam int IDXW = $clog2(REQUESTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQUESTERS-1:0] req,
    output logic                  grant_valid,
    input  logic                  grant_ready,
    output logic [IDXW-1:0]       grant_idx,
    output logic [REQUESTERS-1:0] grant_onehot,
    output logic                  null_input
);

    localparam logic [0:0] c_IDLE  = IDLE;
    localparam logic [0:0] c_GRANT = GRANT;

    logic [0:0]            r_state;
    logic [IDXW-1:0]       r_grant_idx;
    logic [REQUESTERS-1:0] r_grant_onehot;
    logic                  r_null_input;

    logic                  w_accept;
    logic                  w_search;
    logic [IDXW-1:0]       w_mask_from;
    logic [IDXW-1:0]       w_find_idx;
    logic [REQUESTERS-1:0] w_find_onehot;
    logic                  w_find_none;

    // A search happens whenever no grant is held or the held one retires.
    assign w_accept = (r_state == c_GRANT) & grant_ready;
    assign w_search = (r_state == c_IDLE) | w_accept;

`ifdef RR_ARB_ROTATE_EN
    localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(REQUESTERS - 1);

    logic [IDXW-1:0] r_ptr;
    logic [IDXW-1:0] w_ptr_next;

    // Priority moves just past the winner being retired; the updated value
    // feeds the same-cycle search so the served requester is last in line.
    assign w_ptr_next  = (r_grant_idx == c_LAST_IDX) ? '0 : r_grant_idx + IDXW'(1);
    assign w_mask_from = w_accept ? w_ptr_next : r_ptr;

    // Rotation pointer advances only on an accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    // Fixed priority: search always starts at index 0.
    assign w_mask_from = '0;
`endif

    lowest_set_finder #(
        .WIDTH (REQUESTERS)
    ) u_finder (
        .vec       (req),
        .mask_from (w_mask_from),
        .idx       (w_find_idx),
        .onehot    (w_find_onehot),
        .none      (w_find_none)
    );

    // State and output registers; outputs are frozen while a grant waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_null_input   <= 1'b1;
        end else if (w_search) begin
            r_null_input <= w_find_none;
            if (!w_find_none) begin
                r_state        <= c_GRANT;
                r_grant_idx    <= w_find_idx;
                r_grant_onehot <= w_find_onehot;
            end else begin
                r_state        <= c_IDLE;
                r_grant_onehot <= '0;
            end
        end
    end

    assign grant_valid  = (r_state == c_GRANT);
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;
    assign null_input   = r_null_input;

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// ============================================================================
// Module   : tb_rr_priority_arbiter
// Brief    : Scoreboard bench for rr_priority_arbiter (8 and 5 requesters).
//            Expectations follow RR_ARB_ROTATE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_priority_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       grant_valid;
    logic       grant_ready;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic       null_input;

    logic [4:0] req5;
    logic       grant_valid5;
    logic       grant_ready5;
    logic [2:0] grant_idx5;
    logic [4:0] grant_onehot5;
    logic       null_input5;

    int n_checks;
    int n_errors;
    int sb[$];

    rr_priority_arbiter #(.REQUESTERS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_ready  (grant_ready),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .null_input   (null_input)
    );

    rr_priority_arbiter #(.REQUESTERS(5)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .req          (req5),
        .grant_valid  (grant_valid5),
        .grant_ready  (grant_ready5),
        .grant_idx    (grant_idx5),
        .grant_onehot (grant_onehot5),
        .null_input   (null_input5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int idx);
        sb.push_back(idx);
    endtask

    // Monitor: every grant the consumer accepts must match the next expectation.
    always @(negedge clk) begin
        int exp_idx;
        if (!rst && grant_valid && grant_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_grant: got idx %0d, required no grant", grant_idx);
            end else begin
                exp_idx = sb.pop_front();
                check("grant_idx", 32'(grant_idx), 32'(exp_idx));
                check("grant_onehot", 32'(grant_onehot), 32'(1) << exp_idx);
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got time %0t, required finish before limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        req          = 8'h00;
        grant_ready  = 1'b0;
        req5         = 5'b0;
        grant_ready5 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle with no requests.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("idle_valid", 32'(grant_valid), 32'd0);
            check("idle_null", 32'(null_input), 32'd1);
            check("idle_onehot", 32'(grant_onehot), 32'd0);
        end

        // All requesting, consumer always ready.
        @(posedge clk); #1;
`ifdef RR_ARB_ROTATE_EN
        for (int i = 0; i < 8; i++) push(i);
        push(0);
`else
        for (int i = 0; i < 9; i++) push(0);
`endif
        req = 8'hFF;
        grant_ready = 1'b1;
        @(negedge clk);
        check("latency_not_yet_valid", 32'(grant_valid), 32'd0);
        repeat (9) @(posedge clk);
        #1 req = 8'h00;

        // Grant 5, then wrap-around from pointer 6.
        @(posedge clk); #1;
        push(5);
`ifdef RR_ARB_ROTATE_EN
        push(1); push(2);
`else
        push(1); push(1);
`endif
        req = 8'h20;
        @(posedge clk); #1;
        req = 8'b0000_0110;
        repeat (2) @(posedge clk);
        #1 req = 8'h00;

        // Stalled grant is held even after its request drops.
        @(posedge clk); #1;
        grant_ready = 1'b0;
        req = 8'h10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) req = 8'h00;
            @(negedge clk);
            check("hold_valid", 32'(grant_valid), 32'd1);
            check("hold_idx", 32'(grant_idx), 32'd4);
        end
        @(posedge clk); #1;
        push(4);
        grant_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_hold_valid", 32'(grant_valid), 32'd0);
        check("after_hold_null", 32'(null_input), 32'd1);

        // Reset while a grant for requester 3 is pending.
        @(posedge clk); #1;
        grant_ready = 1'b0;
        req = 8'h08;
        @(posedge clk);
        @(negedge clk);
        check("pre_reset_idx", 32'(grant_idx), 32'd3);
        check("pre_reset_valid", 32'(grant_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("reset_valid", 32'(grant_valid), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_onehot", 32'(grant_onehot), 32'd0);
        check("reset_null", 32'(null_input), 32'd1);
        #1;
        rst = 1'b0;
        req = 8'h0C;
        grant_ready = 1'b1;
        push(2);
        @(posedge clk); #1;
        req = 8'h00;

        // Two requesters at the extremes.
        @(posedge clk); #1;
`ifdef RR_ARB_ROTATE_EN
        push(7); push(0); push(7); push(0);
`else
        push(0); push(0); push(0); push(0);
`endif
        req = 8'h81;
        repeat (4) @(posedge clk);
        #1 req = 8'h00;

        // Five-requester instance, top requester only.
        @(posedge clk); #1;
        req5 = 5'b10000;
        grant_ready5 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("r5_valid", 32'(grant_valid5), 32'd1);
            check("r5_idx", 32'(grant_idx5), 32'd4);
            check("r5_onehot", 32'(grant_onehot5), 32'h10);
        end
        req5 = 5'b0;

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
